// File: rtl/muldiv_controller_pkg.sv
// Shared definitions for the M-extension multiply/divide controller.
//   state_e      : controller FSM states
//   muldiv_op_e  : Funct3 encodings of the eight M-extension operations
//   ALUOP_RTYPE / FUNCT7_MULDIV : decode constants for muldiv_sel
package muldiv_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    localparam logic [1:0] ALUOP_RTYPE   = 2'b10;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_iter.sv
// One iteration of the shared multiply/divide datapath.
//   is_div : 1 = restoring-divide step, 0 = shift-add multiply step
//   hi, lo : current accumulator halves
//            multiply: {partial product high, multiplier / product low}
//            divide  : {partial remainder, dividend / quotient}
//   b      : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_nxt, lo_nxt : accumulator after this step
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        // Multiply: conditionally add, keep the carry, shift the pair right.
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : {(WIDTH+1){1'b0}});
        // Divide: bring the next dividend bit into the remainder and trial-subtract.
        // The remainder stays below the divisor, so a clear sign bit means it fits.
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, b};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                hi_nxt = diff[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_controller.sv
// Iterative M-extension multiply/divide unit with valid/ready handshakes.
//   clk, reset           : clock, synchronous active-high reset
//   ALUOp, Funct7, Funct3: instruction decode inputs; muldiv_sel flags an M op
//   in_valid / in_ready  : request handshake, operands rs1 / rs2
//   flush                : abandon whatever is in flight
//   busy                 : stall request to the pipeline
//   out_valid / out_ready: result handshake, result is 0 when not valid
module muldiv_controller
    import muldiv_controller_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FAST_DIV0 = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ALUOp,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             muldiv_sel,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    muldiv_op_e         op_q;
    logic [WIDTH-1:0]   hi_q, lo_q, b_q;
    logic               neg_q;      // negate product / quotient
    logic               rneg_q;     // negate remainder
    logic               special_q;  // divide-by-zero or signed overflow
    logic [WIDTH-1:0]   spec_q;     // precomputed result for the special cases

    logic               accept;
    muldiv_op_e         op_in;
    logic               is_div_in;
    logic               a_sgn, b_sgn;
    logic signed [WIDTH-1:0] rs1_s, rs2_s;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div0, ovf, special_in;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH-1:0]   hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quo_s, rem_s, final_res;

    assign muldiv_sel = (ALUOp == ALUOP_RTYPE) && (Funct7 == FUNCT7_MULDIV);
    assign accept     = in_valid && in_ready && muldiv_sel && !flush;

    // Operand preparation: sign detection, magnitudes and the special cases.
    always_comb begin
        op_in     = muldiv_op_e'(Funct3);
        is_div_in = Funct3[2];
        rs1_s     = signed'(rs1);
        rs2_s     = signed'(rs2);
        a_sgn     = (rs1_s < 0) && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
        b_sgn     = (rs2_s < 0) && (op_in inside {OP_MULH, OP_DIV, OP_REM});
        a_mag     = a_sgn ? -rs1 : rs1;
        b_mag     = b_sgn ? -rs2 : rs2;
        div0      = is_div_in && (rs2 == '0);
        ovf       = (op_in inside {OP_DIV, OP_REM}) &&
                    (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
        special_in = div0 || ovf;
        // Funct3[1] separates the remainder ops from the quotient ops.
        if (div0)
            special_res = Funct3[1] ? rs1 : '1;
        else
            special_res = Funct3[1] ? '0 : rs1;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div (op_q[2]),
        .hi     (hi_q),
        .lo     (lo_q),
        .b      (b_q),
        .hi_nxt (hi_nxt),
        .lo_nxt (lo_nxt)
    );

    // Sign fix-up of the finished accumulator; held stable while in DONE.
    always_comb begin
        prod   = {hi_q, lo_q};
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = rneg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                        final_res = prod_s[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_res = prod_s[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:               final_res = quo_s;
            default:                       final_res = rem_s;
        endcase
        if (special_q)
            final_res = spec_q;
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)
                      state_d = (special_in && (FAST_DIV0 != 0)) ? DONE : CALC;
            CALC: if (cnt_q == LAST_ITER)
                      state_d = DONE;
            DONE: if (out_ready)
                      state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush)
            state_d = IDLE;
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == CALC) || ((state_q == DONE) && !out_ready);
        result    = out_valid ? final_res : '0;
    end

    // Iteration counter and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            op_q      <= OP_MUL;
            hi_q      <= '0;
            lo_q      <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            rneg_q    <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
        end else if (accept) begin
            cnt_q     <= '0;
            op_q      <= op_in;
            hi_q      <= '0;
            // Divide iterates on the dividend; multiply walks the multiplier bits.
            lo_q      <= is_div_in ? a_mag : b_mag;
            b_q       <= is_div_in ? b_mag : a_mag;
            neg_q     <= a_sgn ^ b_sgn;
            rneg_q    <= a_sgn;
            special_q <= special_in;
            spec_q    <= special_res;
        end else if (state_q == CALC) begin
            hi_q  <= hi_nxt;
            lo_q  <= lo_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_muldiv_controller.sv
module tb_muldiv_controller;
    import muldiv_controller_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    ALUOp = 2'b00;
    logic [6:0]    Funct7 = 7'd0;
    logic [2:0]    Funct3 = 3'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic          flush = 1'b0;
    logic          muldiv_sel;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;

    muldiv_controller #(.WIDTH(W), .FAST_DIV0(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .ALUOp      (ALUOp),
        .Funct7     (Funct7),
        .Funct3     (Funct3),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1        (rs1),
        .rs2        (rs2),
        .flush      (flush),
        .muldiv_sel (muldiv_sel),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        int           lat;
        longint       t_acc;
        string        nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each new result and checks value, latency, stability.
    logic         ov_prev = 1'b0;
    logic [W-1:0] held = '0;
    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!out_valid) begin
            check("result_zero_when_invalid", result, '0);
        end else if (!ov_prev) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid actual=0x%08h required=none", result);
            end else begin
                e   = sb.pop_front();
                lat = int'(($time + 5 - e.t_acc) / 10);
                if (result !== e.res) begin
                    errors++;
                    $display("FAIL %s actual=0x%08h required=0x%08h", e.nm, result, e.res);
                end
                check({e.nm, "_latency"}, W'(lat), W'(e.lat));
            end
            held = result;
        end else begin
            check("result_stable", result, held);
        end
        ov_prev = out_valid;
    end

    // Present a request on a negedge once in_ready is up; it is accepted on the next posedge.
    task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_res, input int exp_lat,
                         input string nm, input bit push);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_in_ready"}, W'(in_ready), W'(1));
        ALUOp    = ALUOP_RTYPE;
        Funct7   = FUNCT7_MULDIV;
        Funct3   = f3;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        @(posedge clk);
        if (push) begin
            e.res   = exp_res;
            e.lat   = exp_lat;
            e.t_acc = longint'($time);
            e.nm    = nm;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || !in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d cycles required=<100", nm, n);
        end
    endtask

    task automatic run(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_res, input int exp_lat, input string nm);
        issue(f3, a, b, exp_res, exp_lat, nm, 1'b1);
        drain(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_busy", W'(busy), '0);
        check("rst_result", result, '0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", W'(in_ready), W'(1));

        // in_valid without an M-extension decode is ignored
        ALUOp = 2'b00; Funct7 = FUNCT7_MULDIV; Funct3 = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        check("ignored_sel", W'(muldiv_sel), '0);
        in_valid = 1'b0;
        @(negedge clk);
        check("ignored_in_ready", W'(in_ready), W'(1));
        check("ignored_busy", W'(busy), '0);

        // Main function
        run(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3");
        run(3'd0, 32'h1234_5678, 32'h10,       32'h2345_6780, 33, "mul_shift");
        run(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min_min");
        run(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1");
        run(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div_m7_2");
        run(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem_m7_2");
        run(3'd4, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_7_m2");
        run(3'd6, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, "rem_7_m2");
        run(3'd5, 32'd100,       32'd7,         32'd14,        33, "divu_100_7");
        run(3'd7, 32'd100,       32'd7,         32'd2,         33, "remu_100_7");
        // Boundary cases: fast completion
        run(3'd5, 32'd100,       32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
        run(3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1,  "rem_by0");
        run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  "rem_ovf");

        // Backpressure
        out_ready = 1'b0;
        issue(3'd0, 32'd3, 32'd5, 32'd15, 33, "mul_bp", 1'b1);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid", W'(out_valid), W'(1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_busy", W'(busy), W'(1));
            check("bp_result", result, 32'd15);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", W'(in_ready), W'(1));
        check("bp_release_out_valid", W'(out_valid), '0);

        // Flush at CALC cycle 10
        issue(3'd5, 32'd1000, 32'd3, 32'd0, 0, "flush_op", 1'b0);
        repeat (10) @(negedge clk);
        check("flush_pre_busy", W'(busy), W'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", W'(in_ready), W'(1));
        check("flush_busy", W'(busy), '0);
        repeat (40) @(negedge clk);

        // Flush in the accept cycle discards the request
        ALUOp = ALUOP_RTYPE; Funct7 = FUNCT7_MULDIV; Funct3 = 3'd0;
        rs1 = 32'd2; rs2 = 32'd2; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("flush_accept_in_ready", W'(in_ready), W'(1));
        check("flush_accept_busy", W'(busy), '0);
        repeat (40) @(negedge clk);

        // Reset mid-CALC
        issue(3'd3, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, "reset_op", 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_calc_in_ready", W'(in_ready), W'(1));
        check("rst_calc_busy", W'(busy), '0);
        repeat (40) @(negedge clk);

        // A new request after the aborts completes normally
        run(3'd4, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_after_abort");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%0d required=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
